// File: rtl/decoder_scan_n.sv
`default_nettype none
// ============================================================================
// Module   : decoder_scan_n
// Brief    : Registered N-to-2^N active-low decoder with direct, continuous
//            scan and single-sweep modes, each index held dwell+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_scan_n #(
    parameter int N       = 2,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [N-1:0]         sel,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic                 start,
    output logic [(2**N)-1:0]    y_n,
    output logic [N-1:0]         idx,
    output logic                 valid,
    output logic                 busy,
    output logic                 done
);

    localparam int          c_OUT_W    = 2**N;
    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_DIRECT   = 2'd1;
    localparam logic [1:0]  c_SCAN     = 2'd2;
    localparam logic [1:0]  c_SWEEP    = 2'd3;
    localparam logic [N-1:0] c_IDX_LAST = {N{1'b1}};

    logic [1:0]          r_state;
    logic [N-1:0]        r_idx;
    logic [DWELL_W-1:0]  r_cnt;
    logic [DWELL_W-1:0]  r_dwell_q;
    logic [c_OUT_W-1:0]  r_y_n;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;

    logic [1:0]          w_state_nxt;
    logic [N-1:0]        w_idx_nxt;
    logic [DWELL_W-1:0]  w_cnt_nxt;
    logic [DWELL_W-1:0]  w_dwell_nxt;
    logic                w_done_nxt;
    logic                w_hold_over;
    logic [c_OUT_W-1:0]  w_onehot;
    logic [c_OUT_W-1:0]  w_y_n_nxt;
    logic                w_valid_nxt;
    logic                w_busy_nxt;

    assign w_hold_over = (r_cnt == r_dwell_q);

    // State register: outputs are registered from the next-state values so
    // they change only on clk and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_dwell_q <= '0;
            r_y_n     <= '1;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dwell_q <= w_dwell_nxt;
            r_y_n     <= w_y_n_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state: enable, then mode, then the dwell/advance rule.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_dwell_nxt = r_dwell_q;
        w_done_nxt  = 1'b0;
        if (!en) begin
            w_state_nxt = c_IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else if (mode == 2'b01) begin
            if (r_state != c_SCAN) begin
                w_state_nxt = c_SCAN;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
                w_dwell_nxt = dwell;
            end else if (!w_hold_over) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end else begin
                w_cnt_nxt   = '0;
                w_dwell_nxt = dwell;
                w_idx_nxt   = r_idx + 1'b1;
            end
        end else if (mode == 2'b10) begin
            if (r_state == c_SWEEP) begin
                if (!w_hold_over) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else if (r_idx == c_IDX_LAST) begin
                    w_state_nxt = c_IDLE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = '0;
                    w_dwell_nxt = dwell;
                    w_idx_nxt   = r_idx + 1'b1;
                end
            end else if (start) begin
                w_state_nxt = c_SWEEP;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
                w_dwell_nxt = dwell;
            end else begin
                w_state_nxt = c_IDLE;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        end else begin
            w_state_nxt = c_DIRECT;
            w_idx_nxt   = sel;
            w_cnt_nxt   = '0;
        end
    end

    generate
        for (genvar k = 0; k < c_OUT_W; k++) begin : g_dec
            assign w_onehot[k] = (w_idx_nxt == N'(k));
        end
    endgenerate

    always_comb begin
        w_y_n_nxt   = '1;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = (w_state_nxt == c_SWEEP);
        if (w_state_nxt != c_IDLE) begin
            w_y_n_nxt   = ~w_onehot;
            w_valid_nxt = 1'b1;
        end
    end

    assign y_n   = r_y_n;
    assign idx   = r_idx;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_scan_n
// Brief    : Self-checking bench for decoder_scan_n (N=2 and N=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_scan_n;

    localparam int c_NIDX   = 4;
    localparam int c_M_IDLE = 0;
    localparam int c_M_DIR  = 1;
    localparam int c_M_SCAN = 2;
    localparam int c_M_SWP  = 3;

    logic        clk;
    logic        rst_n;
    logic        en, start;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [3:0]  dwell;
    logic [3:0]  y_n;
    logic [1:0]  idx;
    logic        valid, busy, done;

    logic        en4, start4;
    logic [1:0]  mode4;
    logic [3:0]  sel4;
    logic [3:0]  dwell4;
    logic [15:0] y_n4;
    logic [3:0]  idx4;
    logic        valid4, busy4, done4;

    int checks = 0;
    int errors = 0;

    // reference model: state, index, cycles left at this index, done flag
    int m_st, m_idx, m_left, m_done;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [1:0] sel;
        logic [3:0] dwell;
        logic       start;
        logic [3:0] y_n;
        logic       valid;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[14];

    decoder_scan_n #(.N(2), .DWELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .dwell(dwell), .start(start), .y_n(y_n), .idx(idx),
        .valid(valid), .busy(busy), .done(done)
    );

    decoder_scan_n #(.N(4), .DWELL_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .sel(sel4),
        .dwell(dwell4), .start(start4), .y_n(y_n4), .idx(idx4),
        .valid(valid4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = c_M_IDLE; m_idx = 0; m_left = 0; m_done = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        if (!en) begin
            m_st = c_M_IDLE; m_idx = 0;
        end else if (mode == 2'b01) begin
            if (m_st != c_M_SCAN) begin
                m_st = c_M_SCAN; m_idx = 0; m_left = int'(dwell);
            end else if (m_left > 0) begin
                m_left--;
            end else begin
                m_idx = (m_idx + 1) % c_NIDX; m_left = int'(dwell);
            end
        end else if (mode == 2'b10) begin
            if (m_st == c_M_SWP) begin
                if (m_left > 0) m_left--;
                else if (m_idx == c_NIDX - 1) begin
                    m_st = c_M_IDLE; m_idx = 0; m_done = 1;
                end else begin
                    m_idx++; m_left = int'(dwell);
                end
            end else if (start) begin
                m_st = c_M_SWP; m_idx = 0; m_left = int'(dwell);
            end else begin
                m_st = c_M_IDLE; m_idx = 0;
            end
        end else begin
            m_st = c_M_DIR; m_idx = int'(sel);
        end
    endtask

    task automatic compare_model();
        int exp_y;
        exp_y = (m_st != c_M_IDLE) ? (15 ^ (1 << m_idx)) : 15;
        chk("y_n", 32'(y_n), 32'(exp_y));
        chk("idx", 32'(idx), 32'(m_idx));
        chk("valid", 32'(valid), 32'(m_st != c_M_IDLE));
        chk("busy", 32'(busy), 32'(m_st == c_M_SWP));
        chk("done", 32'(done), 32'(m_done));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic set_in(input logic e, input logic [1:0] m, input logic [1:0] s,
                          input logic [3:0] d, input logic st);
        en = e; mode = m; sel = s; dwell = d; start = st;
    endtask

    initial begin
        int busy_cnt, done_cnt, e_idx;

        tbl[0]  = '{1, 2'b00, 0, 0, 0, 4'b1110, 1, 0, 0};
        tbl[1]  = '{1, 2'b00, 1, 0, 0, 4'b1101, 1, 0, 0};
        tbl[2]  = '{1, 2'b00, 2, 0, 0, 4'b1011, 1, 0, 0};
        tbl[3]  = '{1, 2'b00, 3, 0, 0, 4'b0111, 1, 0, 0};
        tbl[4]  = '{0, 2'b00, 3, 0, 0, 4'b1111, 0, 0, 0};
        tbl[5]  = '{1, 2'b11, 2, 0, 0, 4'b1011, 1, 0, 0};
        tbl[6]  = '{1, 2'b10, 2, 0, 0, 4'b1111, 0, 0, 0};
        tbl[7]  = '{1, 2'b10, 0, 0, 1, 4'b1110, 1, 1, 0};
        tbl[8]  = '{1, 2'b10, 0, 0, 0, 4'b1101, 1, 1, 0};
        tbl[9]  = '{1, 2'b10, 0, 0, 0, 4'b1011, 1, 1, 0};
        tbl[10] = '{1, 2'b10, 0, 0, 0, 4'b0111, 1, 1, 0};
        tbl[11] = '{1, 2'b10, 0, 0, 0, 4'b1111, 0, 0, 1};
        tbl[12] = '{1, 2'b10, 0, 0, 0, 4'b1111, 0, 0, 0};
        tbl[13] = '{1, 2'b01, 0, 0, 1, 4'b1110, 1, 0, 0};

        rst_n = 1'b0;
        set_in(0, 2'b00, 0, 0, 0);
        en4 = 0; mode4 = 2'b00; sel4 = 0; dwell4 = 0; start4 = 0;
        model_reset();
        #12;
        compare_model();
        #5 rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 14; i++) begin
            set_in(tbl[i].en, tbl[i].mode, tbl[i].sel, tbl[i].dwell, tbl[i].start);
            cycle();
            chk($sformatf("tbl%0d_y_n", i), 32'(y_n), 32'(tbl[i].y_n));
            chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
        end

        // scan dwell=2 with wrap
        set_in(1, 2'b00, 0, 0, 0); cycle();
        set_in(1, 2'b01, 0, 2, 0);
        for (int c = 0; c < 13; c++) begin
            cycle();
            chk("scan_idx", 32'(idx), 32'((c / 3) % 4));
        end

        // dwell change during index 1 applies only from index 2
        set_in(1, 2'b00, 0, 0, 0); cycle();
        set_in(1, 2'b01, 0, 2, 0);
        for (int c = 0; c < 10; c++) begin
            cycle();
            case (c)
                0, 1, 2: e_idx = 0;
                3, 4, 5: e_idx = 1;
                6:       e_idx = 2;
                7:       e_idx = 3;
                8:       e_idx = 0;
                default: e_idx = 1;
            endcase
            chk("scan_dwchg_idx", 32'(idx), 32'(e_idx));
            if (c == 3) dwell = 0;
        end

        // sweep dwell=1 with a second start while busy
        set_in(1, 2'b00, 0, 0, 0); cycle();
        set_in(1, 2'b10, 0, 1, 1);
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 11; c++) begin
            cycle();
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (c < 8) chk("sweep_idx", 32'(idx), 32'(c / 2));
            if (c == 8) chk("sweep_end_y_n", 32'(y_n), 32'hF);
            start = (c == 3);
        end
        chk("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("sweep_done_pulses", 32'(done_cnt), 32'd1);

        // abort by en, then by mode 00 sel 3
        for (int a = 0; a < 2; a++) begin
            set_in(1, 2'b00, 0, 0, 0); cycle();
            set_in(1, 2'b10, 0, 1, 1); cycle();
            start = 0;
            for (int c = 1; c < 5; c++) cycle();
            chk("abort_at_idx2", 32'(idx), 32'd2);
            if (a == 0) en = 0;
            else begin mode = 2'b00; sel = 3; end
            cycle();
            chk("abort_y_n", 32'(y_n), (a == 0) ? 32'hF : 32'h7);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            cycle();
            chk("abort_done2", 32'(done), 32'd0);
        end

        // randomized stimulus against the model
        for (int r = 0; r < 400; r++) begin
            set_in($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0) mode = 2'b10 | (mode & 2'b01) ? mode : mode;
            cycle();
            chk("rand_busy_done_excl", 32'(busy & done), 32'd0);
        end

        // asynchronous reset mid-cycle
        set_in(1, 2'b00, 1, 0, 0); cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_y_n", 32'(y_n), 32'hF);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        #2 rst_n = 1'b1;
        set_in(0, 2'b00, 0, 0, 0);

        // wide instance: N=4, dwell=0 scan
        en4 = 1; mode4 = 2'b01; dwell4 = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            chk("n4_idx", 32'(idx4), 32'(c % 16));
            chk("n4_y_n", 32'(y_n4), 32'(16'hFFFF ^ (16'h1 << (c % 16))));
            chk("n4_valid", 32'(valid4), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_scan_n.md
# decoder_scan_n

Parametrised, registered N-to-2^N decoder with active-low one-hot outputs, a global enable, and two self-sequencing modes: continuous scan and single sweep. It generalises the team's 2-to-4 active-low decoder (all outputs high when disabled) to any select width. It adds a programmable per-index dwell timer, so the same block drives multiplexed display digit selects, row strobes, and one-shot bank-enable sequences.

## Interface
Parameters:
- N, 2, select width; output width is 2^N.
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- en  in  1  global enable; low forces all outputs inactive.
- mode  in  2  00 direct, 01 continuous scan, 10 single sweep, 11 treated as direct.
- sel  in  N  index to decode in direct mode.
- dwell  in  DWELL_W  scan/sweep hold; each index is held dwell+1 cycles.
- start  in  1  single-cycle pulse that launches a sweep (mode 10 only).
- y_n  out  2^N  registered active-low one-hot; bit k low means index k is selected.
- idx  out  N  index currently driven; 0 when no output is active.
- valid  out  1  high when exactly one y_n bit is low.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse after the last sweep index ends.

## Operation
- States: IDLE, DIRECT, SCAN, SWEEP. Internal registers:
  - state
  - idx
  - cnt (DWELL_W bits)
  - dwell_q (dwell latched at each index entry)
- Output rule: in DIRECT, SCAN and SWEEP, y_n = ~(1 << idx) and valid = 1. In IDLE, y_n = all ones, valid = 0 and idx = 0.
- Transitions, evaluated every edge in priority order:
  1. en = 0: go to IDLE, clear idx and cnt. An active sweep aborts with no done pulse.
  2. mode is 00 or 11: go to DIRECT, idx <= sel.
  3. mode = 01: if not already in SCAN, enter SCAN with idx <= 0, cnt <= 0, dwell_q <= dwell. Otherwise run the dwell/advance rule.
  4. mode = 10: if in SWEEP, run the dwell/advance rule. If not in SWEEP and start = 1, enter SWEEP at idx 0. If not in SWEEP and start = 0, go to IDLE.
- Dwell/advance rule:
  - If cnt != dwell_q: cnt <= cnt + 1.
  - Otherwise: cnt <= 0, dwell_q <= dwell, idx <= idx + 1.
  - In SCAN, idx wraps from 2^N-1 to 0.
  - In SWEEP, advancing past 2^N-1 goes to IDLE and pulses done for that one cycle.
- A dwell change takes effect only at the next index entry. An index that is already displayed keeps its latched dwell.
- start is ignored outside mode 10, and ignored while busy (no restart).
- Any mode change mid-scan or mid-sweep aborts immediately and applies the new mode's entry action. No done pulse is issued.
- busy = (state == SWEEP). done is registered and is never high in the same cycle as busy.

## Timing
- Reset (async assert, sync-free release):
  - y_n = all ones
  - idx = 0
  - valid = 0
  - busy = 0
  - done = 0
  - state = IDLE
  - cnt = 0, dwell_q = 0
- Direct latency: a sel/en change is visible on y_n one edge later. Outputs never glitch combinationally.
- Disable latency: y_n reaches all ones on the first edge with en = 0 sampled.
- Scan/sweep entry: index 0 is driven from the entry edge. Each index is held dwell+1 cycles. dwell = 0 gives one index per cycle.
- Sweep length: entry edge to return to IDLE is 2^N·(dwell+1) cycles. done is high for the 1 cycle immediately after the last index.
- Wrap-around: in SCAN, index 2^N-1 is followed directly by index 0 with no idle gap.
- If start is high in the cycle en falls, en wins and the state stays IDLE.

## Test plan
(N=2, DWELL_W=4)
- Reset check: assert rst_n=0 mid-cycle -> y_n=4'b1111, valid=0, busy=0 immediately, without waiting for clk.
- Direct mode: en=1, mode=00, sel=0,1,2,3 on successive cycles -> y_n = 1110, 1101, 1011, 0111, each one cycle late. Then en=0 -> 1111 next cycle.
- Continuous scan: mode=01, dwell=2 -> each index held 3 cycles, sequence 1110,1101,1011,0111,1110 (wrap).
  - Then change dwell to 0 during index 1 -> index 1 still held 3 cycles, subsequent indices 1 cycle each.
- Single sweep: mode=10, dwell=1, start pulse -> busy for 8 cycles covering indices 0..3, 2 cycles each. Then done=1 for one cycle, y_n=1111.
  - A second start while busy has no effect.
- Abort: during a sweep at idx=2, drop en -> y_n=1111 next cycle, busy=0, done never asserted.
  - Repeat with mode switched to 00 (sel=3) -> y_n=0111 next cycle, no done.
- Wide parameter: N=4, dwell=0, mode=01 -> 16-cycle cycle through one-hot-low patterns with idx 0..15, then wrap to 0. valid held high throughout.
